// File: rtl/instruction_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch_pkg
// Description : Shared types and constants for the instruction fetch unit:
//               fetch FSM state encoding, the NOP instruction word and the
//               default reset fetch address.
// Revision    : 1.0 - initial release
// ============================================================================
package instruction_fetch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        FLUSH = 2'd2
    } fetch_state_e;

    // ADDI x0, x0, 0 -- presented whenever the buffer head is empty
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// ============================================================================
// Module      : fetch_fifo
// Description : Small synchronous FIFO used for both the instruction buffer
//               and the request tag (address) queue.
// Ports       : clk, rst_n     - clock, synchronous active-low reset
//               flush          - empties the FIFO (wins over push/pop)
//               push/push_data - write request and data
//               pop            - removes the head entry
//               head_data      - current head entry (valid when count != 0)
//               count          - number of stored entries
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        do_pop   = pop && (count_q != '0);
        // A push into a full FIFO is accepted only if the head leaves together
        do_push  = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_data = mem_q[rd_ptr_q];
    assign count     = count_q;

endmodule
`default_nettype wire

// File: rtl/instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : instruction_fetch
// Description : Instruction fetch unit with a split request/response memory
//               port, an in-order instruction buffer and jump redirection that
//               discards responses of requests issued before the jump.
// Ports       : clk, rst_n              - clock, synchronous active-low reset
//               JumpFlag, JumpAddr      - redirect from Execute
//               Stall                   - downstream holds the buffer head
//               imem_req/addr/gnt       - fetch request channel
//               imem_rvalid/rdata       - in-order response channel
//               instruction, pc         - buffer head word and its address
//               InstValid               - buffer head is valid
// Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        JumpFlag,
    input  logic [31:0] JumpAddr,
    input  logic        Stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instruction,
    output logic [31:0] pc,
    output logic        InstValid
);

    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    fetch_state_e     state_q, state_d;
    logic [31:0]      fpc_q, fpc_d;
    logic [CNT_W-1:0] in_flight_q, in_flight_d;
    logic [CNT_W-1:0] discard_q, discard_d;

    logic [CNT_W-1:0] buf_count;
    logic [CNT_W-1:0] tag_count;
    logic [63:0]      buf_head;
    logic [31:0]      tag_head;
    logic [CNT_W:0]   occupancy;
    logic             accept;
    logic             rvalid_ok;
    logic             buf_push;
    logic             buf_pop;
    logic             jump_addr_lsb_unused;
    logic             tag_count_unused;

    assign jump_addr_lsb_unused = ^JumpAddr[1:0];
    assign tag_count_unused     = ^tag_count;

    // Every outstanding request owns a buffer slot, so the buffer cannot overflow
    assign occupancy = {1'b0, in_flight_q} + {1'b0, buf_count};
    assign imem_req  = (state_q == FETCH) && (occupancy < (CNT_W + 1)'(BUF_DEPTH));
    assign imem_addr = fpc_q;
    assign accept    = imem_req && imem_gnt;
    // Responses with nothing outstanding (e.g. after reset) are ignored
    assign rvalid_ok = imem_rvalid && (in_flight_q != '0);

    assign InstValid = (buf_count != '0);
    assign buf_push  = rvalid_ok && (discard_q == '0) && (state_q != FLUSH) && !JumpFlag;
    assign buf_pop   = InstValid && !Stall && !JumpFlag;

    assign instruction = InstValid ? buf_head[31:0]  : NOP_INSTR;
    assign pc          = InstValid ? buf_head[63:32] : fpc_q;

    always_comb begin
        state_d     = state_q;
        fpc_d       = fpc_q;
        in_flight_d = in_flight_q + CNT_W'(accept) - CNT_W'(rvalid_ok);
        discard_d   = discard_q;

        if (rvalid_ok && (discard_q != '0)) begin
            discard_d = discard_q - CNT_W'(1);
        end

        if (JumpFlag) begin
            fpc_d = {JumpAddr[31:2], 2'b00};
        end else if (accept) begin
            fpc_d = fpc_q + 32'd4;
        end

        case (state_q)
            IDLE: begin
                state_d = FETCH;
            end
            FETCH: begin
                if (JumpFlag) begin
                    // Everything still outstanding after this cycle, including
                    // a request granted in the jump cycle itself, is stale
                    discard_d = in_flight_d;
                    state_d   = (in_flight_d != '0) ? FLUSH : FETCH;
                end
            end
            FLUSH: begin
                if (discard_d == '0) begin
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            fpc_q       <= RESET_PC;
            in_flight_q <= '0;
            discard_q   <= '0;
        end else begin
            state_q     <= state_d;
            fpc_q       <= fpc_d;
            in_flight_q <= in_flight_d;
            discard_q   <= discard_d;
        end
    end

    fetch_fifo #(
        .WIDTH (64),
        .DEPTH (BUF_DEPTH)
    ) u_inst_buf (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (JumpFlag),
        .push      (buf_push),
        .push_data ({tag_head, imem_rdata}),
        .pop       (buf_pop),
        .head_data (buf_head),
        .count     (buf_count)
    );

    // Tags pair each response with its request address, discarded or not
    fetch_fifo #(
        .WIDTH (32),
        .DEPTH (BUF_DEPTH)
    ) u_tag_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (1'b0),
        .push      (accept),
        .push_data (fpc_q),
        .pop       (rvalid_ok),
        .head_data (tag_head),
        .count     (tag_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_instruction_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_fetch
// Description : Directed self-checking bench for instruction_fetch. Memory
//               responses are driven by hand, one cycle at a time; read data
//               for address A is 32'hD000_0000 | A unless noted.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instruction_fetch;

    logic        clk;
    logic        rst_n;
    logic        JumpFlag;
    logic [31:0] JumpAddr;
    logic        Stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic        InstValid;

    int n_assert = 0;
    int n_fail   = 0;

    instruction_fetch #(
        .RESET_PC  (32'h0000_0000),
        .BUF_DEPTH (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .JumpFlag    (JumpFlag),
        .JumpAddr    (JumpAddr),
        .Stall       (Stall),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instruction (instruction),
        .pc          (pc),
        .InstValid   (InstValid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance one clock, then clear single-cycle pulses
    task automatic tick();
        @(posedge clk);
        #1;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        JumpFlag    = 1'b0;
        JumpAddr    = 32'h0;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_req"},   {31'd0, imem_req},  32'd0);
        chk({tag, "_addr"},  imem_addr,          32'h0);
        chk({tag, "_valid"}, {31'd0, InstValid}, 32'd0);
        chk({tag, "_instr"}, instruction,        32'h0000_0013);
        chk({tag, "_pc"},    pc,                 32'h0);
    endtask

    initial begin
        rst_n = 1'b0; Stall = 1'b0;
        JumpFlag = 1'b0; JumpAddr = 32'h0;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        tick(); tick();
        #1; chk_reset_values("reset");
        rst_n = 1'b1;

        // c0: IDLE after reset
        #1; chk("c0_req", {31'd0, imem_req}, 32'd0);
        tick();
        // c1: first request at RESET_PC
        #1; chk("c1_req", {31'd0, imem_req}, 32'd1);
        chk("c1_addr", imem_addr, 32'h0);
        imem_gnt = 1'b1;
        tick();
        // c2: second request, response for 0x0
        #1; chk("c2_addr", imem_addr, 32'h4);
        imem_gnt = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hD000_0000;
        tick();
        // c3: first instruction visible; buffer+in-flight full, no request
        #1; chk("c3_valid", {31'd0, InstValid}, 32'd1);
        chk("c3_pc", pc, 32'h0);
        chk("c3_instr", instruction, 32'hD000_0000);
        chk("c3_req", {31'd0, imem_req}, 32'd0);
        imem_rvalid = 1'b1; imem_rdata = 32'hD000_0004;
        tick();
        // c4
        #1; chk("c4_pc", pc, 32'h4);
        chk("c4_instr", instruction, 32'hD000_0004);
        chk("c4_addr", imem_addr, 32'h8);
        imem_gnt = 1'b1;
        tick();
        // c5
        #1; chk("c5_addr", imem_addr, 32'hC);
        imem_gnt = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hD000_0008;
        tick();
        // c6: stall begins, last response fills the buffer
        #1; chk("c6_pc", pc, 32'h8);
        chk("c6_req", {31'd0, imem_req}, 32'd0);
        Stall = 1'b1;
        imem_rvalid = 1'b1; imem_rdata = 32'hD000_000C;
        tick();
        // c7..c11: five stalled cycles with a full buffer
        for (int i = 0; i < 5; i++) begin
            #1; chk("stall_req", {31'd0, imem_req}, 32'd0);
            chk("stall_pc", pc, 32'h8);
            chk("stall_instr", instruction, 32'hD000_0008);
            chk("stall_valid", {31'd0, InstValid}, 32'd1);
            tick();
        end
        // c12: release
        Stall = 1'b0;
        #1; chk("c12_pc", pc, 32'h8);
        tick();
        // c13: 0xC follows 0x8, request for 0x10
        #1; chk("c13_pc", pc, 32'hC);
        chk("c13_instr", instruction, 32'hD000_000C);
        chk("c13_addr", imem_addr, 32'h10);
        imem_gnt = 1'b1;
        tick();
        // c14: nothing duplicated, request for 0x14
        #1; chk("c14_valid", {31'd0, InstValid}, 32'd0);
        chk("c14_addr", imem_addr, 32'h14);
        imem_gnt = 1'b1;
        tick();
        // c15: two in flight, jump to unaligned 0x103
        #1; chk("c15_req", {31'd0, imem_req}, 32'd0);
        JumpFlag = 1'b1; JumpAddr = 32'h0000_0103;
        tick();
        // c16, c17: FLUSH drops both responses
        #1; chk("c16_req", {31'd0, imem_req}, 32'd0);
        imem_rvalid = 1'b1; imem_rdata = 32'hD000_0010;
        tick();
        #1; chk("c17_req", {31'd0, imem_req}, 32'd0);
        chk("c17_valid", {31'd0, InstValid}, 32'd0);
        imem_rvalid = 1'b1; imem_rdata = 32'hD000_0014;
        tick();
        // c18: back in FETCH at the aligned target
        #1; chk("c18_valid", {31'd0, InstValid}, 32'd0);
        chk("c18_req", {31'd0, imem_req}, 32'd1);
        chk("c18_addr", imem_addr, 32'h100);
        imem_gnt = 1'b1;
        tick();
        #1; imem_rvalid = 1'b1; imem_rdata = 32'hD000_0100;
        tick();
        // c20: first delivered after the jump is 0x100; jump with nothing in flight
        #1; chk("c20_pc", pc, 32'h100);
        chk("c20_instr", instruction, 32'hD000_0100);
        JumpFlag = 1'b1; JumpAddr = 32'h0000_001C;
        tick();
        // c21: direct to FETCH, request at new address one cycle later
        #1; chk("c21_valid", {31'd0, InstValid}, 32'd0);
        chk("c21_req", {31'd0, imem_req}, 32'd1);
        chk("c21_addr", imem_addr, 32'h1C);
        imem_gnt = 1'b1;
        tick();
        // c22: gnt for 0x20, rvalid for 0x1C and a jump, all together
        #1; chk("c22_addr", imem_addr, 32'h20);
        imem_gnt = 1'b1; imem_rvalid = 1'b1; imem_rdata = 32'hD000_001C;
        JumpFlag = 1'b1; JumpAddr = 32'h0000_0040;
        tick();
        // c23: 0x1C not delivered; 0x20 response discarded
        #1; chk("c23_valid", {31'd0, InstValid}, 32'd0);
        chk("c23_req", {31'd0, imem_req}, 32'd0);
        imem_rvalid = 1'b1; imem_rdata = 32'hD000_0020;
        tick();
        // c24
        #1; chk("c24_valid", {31'd0, InstValid}, 32'd0);
        chk("c24_addr", imem_addr, 32'h40);
        imem_gnt = 1'b1;
        tick();
        #1; imem_rvalid = 1'b1; imem_rdata = 32'hD000_0040;
        tick();
        // c26: first delivered is the jump target
        #1; chk("c26_pc", pc, 32'h40);
        chk("c26_instr", instruction, 32'hD000_0040);
        JumpFlag = 1'b1; JumpAddr = 32'hFFFF_FFFC;
        tick();
        // c27, c28: address wraps to zero
        #1; chk("c27_addr", imem_addr, 32'hFFFF_FFFC);
        imem_gnt = 1'b1;
        tick();
        #1; chk("c28_req", {31'd0, imem_req}, 32'd1);
        chk("c28_addr", imem_addr, 32'h0);
        imem_gnt = 1'b1;
        tick();
        // c29: two in flight, reset for one cycle
        #1; chk("c29_req", {31'd0, imem_req}, 32'd0);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        // c30: reset values, stray response ignored
        #1; chk_reset_values("midreset");
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        #1; chk("c31_valid", {31'd0, InstValid}, 32'd0);
        chk("c31_addr", imem_addr, 32'h0);
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        tick();
        #1; chk("c32_valid", {31'd0, InstValid}, 32'd0);
        imem_gnt = 1'b1;
        tick();
        #1; chk("c33_valid", {31'd0, InstValid}, 32'd0);
        imem_rvalid = 1'b1; imem_rdata = 32'hD000_0000;
        tick();
        #1; chk("c34_valid", {31'd0, InstValid}, 32'd1);
        chk("c34_pc", pc, 32'h0);
        chk("c34_instr", instruction, 32'hD000_0000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
